// File: rtl/alu_writeback_pkg.sv
// Shared types for the ALU writeback block.
// Phase encoding and FIFO entry field layout.
package alu_writeback_pkg;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_t;

  // Entry layout, LSB first: y2 | y1 | rd2 | rd1 | dual
  function automatic int entry_w(int dw, int aw);
    return 1 + 2 * aw + 2 * dw;
  endfunction

  function automatic int off_y1(int dw);
    return dw;
  endfunction

  function automatic int off_rd2(int dw);
    return 2 * dw;
  endfunction

  function automatic int off_rd1(int dw, int aw);
    return 2 * dw + aw;
  endfunction

  function automatic int off_dual(int dw, int aw);
    return 2 * dw + 2 * aw;
  endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Result-pair handshake and register file write port.
// master = ALU / regfile side, slave = writeback block.
interface alu_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_dual;
  logic [ADDR_W-1:0]        in_rd1;
  logic [ADDR_W-1:0]        in_rd2;
  logic [DATA_W-1:0]        in_y1;
  logic [DATA_W-1:0]        in_y2;
  logic                     wr_stall;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_dual, in_rd1, in_rd2,
    output in_y1, in_y2, wr_stall,
    input  in_ready, wr_en, wr_addr, wr_data, count
  );

  modport slave (
    input  in_valid, in_dual, in_rd1, in_rd2,
    input  in_y1, in_y2, wr_stall,
    output in_ready, wr_en, wr_addr, wr_data, count
  );
endinterface

// File: rtl/alu_writeback_result_fifo.sv
// Synchronous FIFO with occupancy count.
// Full/empty come from the count, pointers wrap mod DEPTH.
module result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  // Storage array, written on push only
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/alu_writeback.sv
// ALU dual-result writeback: buffers result pairs and
// serialises them onto the single regfile write port.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_writeback_if.slave bus
);
  localparam int EW = entry_w(DATA_W, ADDR_W);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OY1 = off_y1(DATA_W);
  localparam int OR2 = off_rd2(DATA_W);
  localparam int OR1 = off_rd1(DATA_W, ADDR_W);
  localparam int ODL = off_dual(DATA_W, ADDR_W);

  phase_t              r_phase;
  phase_t              w_phase_nxt;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic                w_en_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_push;
  logic                w_pop;
  logic                w_ready;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [EW-1:0]       w_din;
  logic [EW-1:0]       w_dout;
  logic                w_dual;
  logic [ADDR_W-1:0]   w_rd1;
  logic [ADDR_W-1:0]   w_rd2;
  logic [DATA_W-1:0]   w_y1;
  logic [DATA_W-1:0]   w_y2;

  assign w_ready = (w_count != CW'(DEPTH));
  assign w_empty = (w_count == '0);
  assign w_push  = bus.in_valid & w_ready;
  assign w_din   = {bus.in_dual, bus.in_rd1, bus.in_rd2,
                    bus.in_y1, bus.in_y2};

  assign w_dual = w_dout[ODL];
  assign w_rd1  = w_dout[OR1 +: ADDR_W];
  assign w_rd2  = w_dout[OR2 +: ADDR_W];
  assign w_y1   = w_dout[OY1 +: DATA_W];
  assign w_y2   = w_dout[0 +: DATA_W];

  result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_dout),
    .o_count (w_count)
  );

  // Phase FSM next-state and write slot selection
  always_comb begin
    w_phase_nxt = r_phase;
    w_pop       = 1'b0;
    w_en_nxt    = 1'b0;
    w_addr_nxt  = r_wr_addr;
    w_data_nxt  = r_wr_data;
    if (!bus.wr_stall) begin
      unique case (r_phase)
        PH_FIRST: begin
          if (!w_empty) begin
            w_addr_nxt = w_rd1;
            w_data_nxt = w_y1;
            w_en_nxt   = (w_rd1 != '0);
            if (w_dual) w_phase_nxt = PH_SECOND;
            else        w_pop       = 1'b1;
          end
        end
        PH_SECOND: begin
          w_addr_nxt  = w_rd2;
          w_data_nxt  = w_y2;
          w_en_nxt    = (w_rd2 != '0);
          w_pop       = 1'b1;
          w_phase_nxt = PH_FIRST;
        end
        default: w_phase_nxt = PH_FIRST;
      endcase
    end
  end

  // Phase register and registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= PH_FIRST;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_phase   <= w_phase_nxt;
      r_wr_en   <= w_en_nxt;
      r_wr_addr <= w_addr_nxt;
      r_wr_data <= w_data_nxt;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.count    = w_count;
endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: queue-of-writes model
// checked every cycle plus directed literal checks.
module tb_alu_writeback;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_writeback_if #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) bus ();

  alu_writeback #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            last;
  } slot_t;

  slot_t          mq[$];
  logic           m_en = 1'b0;
  logic [AW-1:0]  m_addr = '0;
  logic [DW-1:0]  m_data = '0;

  function automatic int m_cnt();
    int n = 0;
    foreach (mq[i]) if (mq[i].last) n++;
    return n;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each accepted pair becomes one or two write slots;
  // each unstalled cycle retires one slot.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_en = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      slot_t s;
      bit rdy;
      rdy = (m_cnt() < DP);
      if (!bus.wr_stall && mq.size() > 0) begin
        s = mq.pop_front();
        m_en = (s.addr != 0);
        m_addr = s.addr;
        m_data = s.data;
      end else begin
        m_en = 1'b0;
      end
      if (bus.in_valid && rdy) begin
        mq.push_back('{bus.in_rd1, bus.in_y1, !bus.in_dual});
        if (bus.in_dual)
          mq.push_back('{bus.in_rd2, bus.in_y2, 1'b1});
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("wr_en", 32'(bus.wr_en), 32'(m_en));
    if (m_en) begin
      chk("wr_addr", 32'(bus.wr_addr), 32'(m_addr));
      chk("wr_data", bus.wr_data, m_data);
    end
    chk("count", 32'(bus.count), 32'(m_cnt()));
    chk("in_ready", 32'(bus.in_ready), 32'(m_cnt() < DP));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pair(logic d, logic [AW-1:0] r1,
                          logic [AW-1:0] r2,
                          logic [DW-1:0] a, logic [DW-1:0] b);
    bus.in_valid = 1'b1;
    bus.in_dual  = d;
    bus.in_rd1   = r1;
    bus.in_rd2   = r2;
    bus.in_y1    = a;
    bus.in_y2    = b;
  endtask

  task automatic push(logic d, logic [AW-1:0] r1,
                      logic [AW-1:0] r2,
                      logic [DW-1:0] a, logic [DW-1:0] b);
    set_pair(d, r1, r2, a, b);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wr_is(string nm, logic [AW-1:0] a, logic [DW-1:0] d);
    chk({nm, "_en"}, 32'(bus.wr_en), 32'd1);
    chk({nm, "_addr"}, 32'(bus.wr_addr), 32'(a));
    chk({nm, "_data"}, bus.wr_data, d);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_dual  = 1'b0;
    bus.in_rd1   = '0;
    bus.in_rd2   = '0;
    bus.in_y1    = '0;
    bus.in_y2    = '0;
    bus.wr_stall = 1'b0;
    #23;
    chk("rst_en", 32'(bus.wr_en), 32'd0);
    chk("rst_cnt", 32'(bus.count), 32'd0);
    chk("rst_addr", 32'(bus.wr_addr), 32'd0);
    chk("rst_data", bus.wr_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    // single result
    push(1'b0, 5'd3, 5'd0, 32'h11111111, 32'h0);
    chk("s_cnt1", 32'(bus.count), 32'd1);
    chk("s_en0", 32'(bus.wr_en), 32'd0);
    tick();
    wr_is("s_w", 5'd3, 32'h11111111);
    chk("s_cnt0", 32'(bus.count), 32'd0);
    tick();
    chk("s_idle", 32'(bus.wr_en), 32'd0);

    // dual result
    push(1'b1, 5'd4, 5'd5, 32'hA, 32'hB);
    tick();
    wr_is("d_y1", 5'd4, 32'hA);
    chk("d_cnt1", 32'(bus.count), 32'd1);
    tick();
    wr_is("d_y2", 5'd5, 32'hB);
    chk("d_cnt0", 32'(bus.count), 32'd0);
    tick();

    // backpressure fill
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 4; i++)
      push(1'b0, 5'(8 + i), 5'd0, 32'h100 + i, 32'h0);
    chk("bp_cnt", 32'(bus.count), 32'd4);
    chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    chk("bp_en", 32'(bus.wr_en), 32'd0);
    push(1'b0, 5'd12, 5'd0, 32'hDEAD, 32'h0);
    chk("bp_5th", 32'(bus.count), 32'd4);
    bus.wr_stall = 1'b0;
    tick();
    wr_is("bp_w0", 5'd8, 32'h100);
    chk("bp_rdy1", 32'(bus.in_ready), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      wr_is("bp_w", 5'(8 + i), 32'h100 + i);
    end
    tick();
    chk("bp_done", 32'(bus.wr_en), 32'd0);

    // stall during second phase
    push(1'b1, 5'd13, 5'd14, 32'hC1, 32'hC2);
    tick();
    wr_is("sm_y1", 5'd13, 32'hC1);
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sm_hold", 32'(bus.wr_en), 32'd0);
    end
    bus.wr_stall = 1'b0;
    tick();
    wr_is("sm_y2", 5'd14, 32'hC2);
    tick();

    // register zero and same destination
    push(1'b1, 5'd0, 5'd0, 32'hD1, 32'hD2);
    tick();
    chk("z_en1", 32'(bus.wr_en), 32'd0);
    chk("z_cnt1", 32'(bus.count), 32'd1);
    tick();
    chk("z_en2", 32'(bus.wr_en), 32'd0);
    chk("z_cnt2", 32'(bus.count), 32'd0);
    push(1'b1, 5'd7, 5'd7, 32'd1, 32'd2);
    tick();
    wr_is("sd_1", 5'd7, 32'd1);
    tick();
    wr_is("sd_2", 5'd7, 32'd2);
    tick();

    // back-to-back burst, mixed single and dual
    for (int i = 0; i < 6; i++) begin
      set_pair(i == 3, 5'(20 + i), 5'(26 + i),
               32'h5000 + i, 32'h6000 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (6) tick();

    // async reset mid-drain
    bus.wr_stall = 1'b1;
    for (int i = 0; i < 3; i++)
      push(1'b1, 5'(16 + 2 * i), 5'(17 + 2 * i),
           32'hE0 + i, 32'hF0 + i);
    chk("ar_cnt", 32'(bus.count), 32'd3);
    bus.wr_stall = 1'b0;
    tick();
    wr_is("ar_y1", 5'd16, 32'hE0);
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(bus.wr_en), 32'd0);
    chk("ar_cnt0", 32'(bus.count), 32'd0);
    chk("ar_addr", 32'(bus.wr_addr), 32'd0);
    chk("ar_data", bus.wr_data, 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_stale", 32'(bus.wr_en), 32'd0);
    end
    chk("ar_rdy", 32'(bus.in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
